// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, opcode constants and instruction field helpers
package cpu_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_REG_ADDR_W = 4;
    localparam int DEF_OPC_W      = 4;
    localparam int DEF_INST_W     = 16;
    localparam int DEF_PC_W       = 16;

    localparam logic [3:0] OPC_LOAD = 4'h8;
    localparam logic [3:0] OPC_IMM  = 4'h9;
    localparam logic [3:0] OPC_BR   = 4'hF;

    // Callers cast the 32-bit result down to the field width they need.
    function automatic logic [31:0] getField(input logic [31:0] word, input int lsb, input int width);
        logic [31:0] mask;
        mask = (32'h1 << width) - 32'h1;
        return (word >> lsb) & mask;
    endfunction

    function automatic logic [31:0] signExtend(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (32'h1 << width) - 32'h1;
        if (((value >> (width - 1)) & 32'h1) != 32'h0) begin
            return value | ~mask;
        end
        return value & mask;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// rtl/regfile_bypass.sv - register file with hard-wired R0 and write-back bypass
module regfile_bypass
    import cpu_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_REG_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr1,
    input  logic [ADDR_W-1:0] rdAddr2,
    output logic [DATA_W-1:0] rdData1,
    output logic [DATA_W-1:0] rdData2
);

    localparam int NREG = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic              wrLive;

    assign wrLive = wrEn && (wrAddr != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (wrLive) begin
            regs[wrAddr] <= wrData;
        end
    end

    // A write landing this cycle is forwarded so decode never sees stale data.
    always_comb begin
        rdData1 = '0;
        if (rdAddr1 != '0) begin
            rdData1 = (wrLive && wrAddr == rdAddr1) ? wrData : regs[rdAddr1];
        end
    end

    always_comb begin
        rdData2 = '0;
        if (rdAddr2 != '0) begin
            rdData2 = (wrLive && wrAddr == rdAddr2) ? wrData : regs[rdAddr2];
        end
    end

endmodule

// File: rtl/decode_pipe.sv
// rtl/decode_pipe.sv - decode stage: field split, operand read, branch resolve, hazard and D/E register
module decode_pipe
    import cpu_pkg::*;
#(
    parameter int               DATA_W     = DEF_DATA_W,
    parameter int               REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int               OPC_W      = DEF_OPC_W,
    parameter int               INST_W     = DEF_INST_W,
    parameter int               PC_W       = DEF_PC_W,
    parameter logic [OPC_W-1:0] LOAD_OPC   = OPC_LOAD,
    parameter logic [OPC_W-1:0] IMM_OPC    = OPC_IMM,
    parameter logic [OPC_W-1:0] BR_OPC     = OPC_BR
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_W-1:0]     inst_d,
    input  logic [PC_W-1:0]       pc_d,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data,
    output logic                  e_valid,
    output logic [OPC_W-1:0]      e_opcode,
    output logic [REG_ADDR_W-1:0] e_src1,
    output logic [REG_ADDR_W-1:0] e_src2,
    output logic [REG_ADDR_W-1:0] e_dest,
    output logic [DATA_W-1:0]     e_data1,
    output logic [DATA_W-1:0]     e_data2,
    output logic [PC_W-1:0]       e_pc,
    output logic                  br_take,
    output logic [PC_W-1:0]       br_target,
    output logic                  hazard_stall
);

    logic [OPC_W-1:0]      opcode;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     rfData1;
    logic [DATA_W-1:0]     rfData2;
    logic [DATA_W-1:0]     data2;
    logic                  isImm;
    logic                  isBr;
    logic                  loadHit;
    logic                  accept;
    logic                  squash;

    assign opcode = OPC_W'(getField(32'(inst_d), INST_W - OPC_W, OPC_W));
    assign src1   = REG_ADDR_W'(getField(32'(inst_d), 2 * REG_ADDR_W, REG_ADDR_W));
    assign src2   = REG_ADDR_W'(getField(32'(inst_d), REG_ADDR_W, REG_ADDR_W));
    assign dest   = REG_ADDR_W'(getField(32'(inst_d), 0, REG_ADDR_W));

    assign isImm = (opcode == IMM_OPC);
    assign isBr  = (opcode == BR_OPC);

    regfile_bypass #(
        .DATA_W (DATA_W),
        .ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .wrEn    (wb_en),
        .wrAddr  (wb_addr),
        .wrData  (wb_data),
        .rdAddr1 (src1),
        .rdAddr2 (src2),
        .rdData1 (rfData1),
        .rdData2 (rfData2)
    );

    assign data2 = isImm ? DATA_W'(signExtend(32'(src2), REG_ADDR_W)) : rfData2;

    // The immediate form carries a constant in src2, so only src1 can depend on the load.
    assign loadHit = (e_dest == src1) || (!isImm && (e_dest == src2));
    assign hazard_stall = in_valid && e_valid && (e_opcode == LOAD_OPC) &&
                          (e_dest != '0) && loadHit && !isBr;

    assign in_ready  = !stall_i && !hazard_stall;
    assign accept    = in_valid && in_ready;
    assign br_take   = accept && isBr && !squash && !flush_i;
    assign br_target = pc_d + PC_W'(signExtend(32'(dest), REG_ADDR_W));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_valid  <= 1'b0;
            e_opcode <= '0;
            e_src1   <= '0;
            e_src2   <= '0;
            e_dest   <= '0;
            e_data1  <= '0;
            e_data2  <= '0;
            e_pc     <= '0;
            squash   <= 1'b0;
        end else if (flush_i) begin
            e_valid <= 1'b0;
            squash  <= 1'b0;
        end else if (stall_i) begin
            e_valid <= e_valid;
        end else if (hazard_stall) begin
            e_valid <= 1'b0;
        end else if (accept) begin
            e_valid  <= !squash;
            e_opcode <= opcode;
            e_src1   <= src1;
            e_src2   <= src2;
            e_dest   <= dest;
            e_data1  <= rfData1;
            e_data2  <= data2;
            e_pc     <= pc_d;
            // A branch in the shadow is itself killed and must not arm another squash.
            squash   <= isBr && !squash;
        end else begin
            e_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_pipe.sv
// tb/tb_decode_pipe.sv - self-checking bench for decode_pipe
module tb_decode_pipe;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] inst_d;
    logic [15:0] pc_d;
    logic        stall_i;
    logic        flush_i;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        e_valid;
    logic [3:0]  e_opcode;
    logic [3:0]  e_src1;
    logic [3:0]  e_src2;
    logic [3:0]  e_dest;
    logic [15:0] e_data1;
    logic [15:0] e_data2;
    logic [15:0] e_pc;
    logic        br_take;
    logic [15:0] br_target;
    logic        hazard_stall;

    int passed = 0;
    int total  = 0;

    decode_pipe dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .inst_d       (inst_d),
        .pc_d         (pc_d),
        .stall_i      (stall_i),
        .flush_i      (flush_i),
        .wb_en        (wb_en),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .e_valid      (e_valid),
        .e_opcode     (e_opcode),
        .e_src1       (e_src1),
        .e_src2       (e_src2),
        .e_dest       (e_dest),
        .e_data1      (e_data1),
        .e_data2      (e_data2),
        .e_pc         (e_pc),
        .br_take      (br_take),
        .br_target    (br_target),
        .hazard_stall (hazard_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        inValid;
        logic [15:0] inst;
        logic [15:0] pc;
        logic        flush;
        logic        wbEn;
        logic [3:0]  wbAddr;
        logic [15:0] wbData;
        logic        expReady;
        logic        expBr;
        logic        chkTarget;
        logic [15:0] expTarget;
        logic        expHaz;
        logic        expEValid;
        logic        chkData;
        logic [15:0] expD1;
        logic [15:0] expD2;
        logic [3:0]  expDest;
    } vec_t;

    typedef struct {
        int          idx;
        logic        eValid;
        logic        chkData;
        logic [15:0] d1;
        logic [15:0] d2;
        logic [3:0]  dest;
    } exp_t;

    localparam int NV = 25;
    vec_t vecs [NV];
    exp_t sb [$];

    function automatic logic [15:0] ins(input logic [3:0] opc, input logic [3:0] s1,
                                        input logic [3:0] s2, input logic [3:0] d);
        return {opc, s1, s2, d};
    endfunction

    function automatic vec_t mk(input logic iv, input logic [15:0] inst, input logic [15:0] pc,
                                input logic fl, input logic we, input logic [3:0] wa,
                                input logic [15:0] wd, input logic rdy, input logic br,
                                input logic ct, input logic [15:0] tgt, input logic hz,
                                input logic ev, input logic cd, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [3:0] de);
        vec_t v;
        v.inValid = iv; v.inst = inst; v.pc = pc; v.flush = fl;
        v.wbEn = we; v.wbAddr = wa; v.wbData = wd;
        v.expReady = rdy; v.expBr = br; v.chkTarget = ct; v.expTarget = tgt;
        v.expHaz = hz; v.expEValid = ev; v.chkData = cd;
        v.expD1 = d1; v.expD2 = d2; v.expDest = de;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic drive(input logic iv, input logic [15:0] inst, input logic [15:0] pc,
                         input logic st, input logic fl);
        in_valid = iv;
        inst_d   = inst;
        pc_d     = pc;
        stall_i  = st;
        flush_i  = fl;
        wb_en    = 1'b0;
        wb_addr  = 4'h0;
        wb_data  = 16'h0;
    endtask

    task automatic checkE(input string tag, input logic ev, input logic [15:0] d1,
                          input logic [15:0] d2, input logic [15:0] pc);
        check({tag, " e_valid"}, 32'(e_valid), 32'(ev));
        check({tag, " e_data1"}, 32'(e_data1), 32'(d1));
        check({tag, " e_data2"}, 32'(e_data2), 32'(d2));
        check({tag, " e_pc"},    32'(e_pc),    32'(pc));
    endtask

    initial begin
        vecs[0]  = mk(0, 16'h0,            16'h0000, 0, 1, 4'h1, 16'h1111, 1, 0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[1]  = mk(0, 16'h0,            16'h0000, 0, 1, 4'h2, 16'h2222, 1, 0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[2]  = mk(0, 16'h0,            16'h0000, 0, 1, 4'h0, 16'h1234, 1, 0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[3]  = mk(1, ins(1, 1, 2, 3),  16'h0020, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 16'h2222, 4'h3);
        vecs[4]  = mk(1, ins(1, 0, 0, 6),  16'h0022, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h0,    16'h0,    4'h6);
        vecs[5]  = mk(1, ins(1, 5, 1, 7),  16'h0024, 0, 1, 4'h5, 16'hBEEF, 1, 0, 0, 16'h0,    0, 1, 1, 16'hBEEF, 16'h1111, 4'h7);
        vecs[6]  = mk(1, ins(1, 5, 5, 7),  16'h0026, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'hBEEF, 16'hBEEF, 4'h7);
        vecs[7]  = mk(1, ins(8, 1, 0, 4),  16'h0030, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 16'h0,    4'h4);
        vecs[8]  = mk(1, ins(1, 4, 2, 9),  16'h0032, 0, 0, 4'h0, 16'h0,    0, 0, 0, 16'h0,    1, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[9]  = mk(1, ins(1, 4, 2, 9),  16'h0032, 0, 1, 4'h4, 16'h4444, 1, 0, 0, 16'h0,    0, 1, 1, 16'h4444, 16'h2222, 4'h9);
        vecs[10] = mk(1, ins(8, 0, 0, 15), 16'h0034, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h0,    16'h0,    4'hF);
        vecs[11] = mk(1, ins(9, 1, 15, 2), 16'h0036, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 16'hFFFF, 4'h2);
        vecs[12] = mk(1, ins(8, 0, 0, 4),  16'h0038, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h0,    16'h0,    4'h4);
        vecs[13] = mk(1, ins(15, 4, 0, 14),16'h0010, 0, 0, 4'h0, 16'h0,    1, 1, 1, 16'h000E, 0, 1, 1, 16'h4444, 16'h0,    4'hE);
        vecs[14] = mk(1, ins(1, 1, 2, 3),  16'h0012, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 0, 1, 16'h1111, 16'h2222, 4'h3);
        vecs[15] = mk(1, ins(1, 2, 1, 3),  16'h0014, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h2222, 16'h1111, 4'h3);
        vecs[16] = mk(1, ins(15, 0, 0, 1), 16'hFFFF, 0, 0, 4'h0, 16'h0,    1, 1, 1, 16'h0000, 0, 1, 1, 16'h0,    16'h0,    4'h1);
        vecs[17] = mk(0, 16'h0,            16'h0000, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[18] = mk(1, ins(1, 1, 1, 3),  16'h0002, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 0, 1, 16'h1111, 16'h1111, 4'h3);
        vecs[19] = mk(1, ins(1, 1, 2, 6),  16'h0004, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 16'h2222, 4'h6);
        vecs[20] = mk(1, ins(15, 0, 0, 2), 16'h0040, 0, 0, 4'h0, 16'h0,    1, 1, 1, 16'h0042, 0, 1, 1, 16'h0,    16'h0,    4'h2);
        vecs[21] = mk(1, ins(15, 0, 0, 2), 16'h0042, 0, 0, 4'h0, 16'h0,    1, 0, 1, 16'h0044, 0, 0, 1, 16'h0,    16'h0,    4'h2);
        vecs[22] = mk(1, ins(1, 1, 2, 7),  16'h0044, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h1111, 16'h2222, 4'h7);
        vecs[23] = mk(1, ins(15, 0, 0, 2), 16'h0044, 1, 0, 4'h0, 16'h0,    1, 0, 1, 16'h0046, 0, 0, 0, 16'h0,    16'h0,    4'h0);
        vecs[24] = mk(1, ins(1, 2, 2, 5),  16'h0050, 0, 0, 4'h0, 16'h0,    1, 0, 0, 16'h0,    0, 1, 1, 16'h2222, 16'h2222, 4'h5);

        reset = 1'b1;
        drive(0, 16'h0, 16'h0, 0, 0);
        #12;
        checkE("reset", 0, 16'h0, 16'h0, 16'h0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset br_take", 32'(br_take), 32'd0);
        check("reset hazard_stall", 32'(hazard_stall), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            exp_t e;
            @(negedge clk);
            drive(vecs[i].inValid, vecs[i].inst, vecs[i].pc, 1'b0, vecs[i].flush);
            wb_en   = vecs[i].wbEn;
            wb_addr = vecs[i].wbAddr;
            wb_data = vecs[i].wbData;
            #1;
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'(vecs[i].expReady));
            check($sformatf("v%0d br_take", i), 32'(br_take), 32'(vecs[i].expBr));
            check($sformatf("v%0d hazard_stall", i), 32'(hazard_stall), 32'(vecs[i].expHaz));
            if (vecs[i].chkTarget) begin
                check($sformatf("v%0d br_target", i), 32'(br_target), 32'(vecs[i].expTarget));
            end
            sb.push_back('{i, vecs[i].expEValid, vecs[i].chkData,
                           vecs[i].expD1, vecs[i].expD2, vecs[i].expDest});
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check($sformatf("v%0d e_valid", e.idx), 32'(e_valid), 32'(e.eValid));
            if (e.chkData) begin
                check($sformatf("v%0d e_data1", e.idx), 32'(e_data1), 32'(e.d1));
                check($sformatf("v%0d e_data2", e.idx), 32'(e_data2), 32'(e.d2));
                check($sformatf("v%0d e_dest", e.idx), 32'(e_dest), 32'(e.dest));
            end
        end

        // Three-cycle stall with a branch waiting: D/E holds the ADD at pc 0x50.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            drive(1, ins(15, 0, 0, 3), 16'h0070, 1, 0);
            #1;
            check($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
            check($sformatf("stall%0d br_take", k), 32'(br_take), 32'd0);
            @(posedge clk);
            #1;
            checkE($sformatf("stall%0d", k), 1, 16'h2222, 16'h2222, 16'h0050);
            check($sformatf("stall%0d e_dest", k), 32'(e_dest), 32'h5);
        end

        // Flush under stall clears the squash armed by the preceding branch.
        @(negedge clk);
        drive(1, ins(15, 0, 0, 2), 16'h0060, 0, 0);
        #1;
        check("flsq br_take", 32'(br_take), 32'd1);
        @(negedge clk);
        drive(1, ins(1, 1, 2, 3), 16'h0062, 1, 1);
        @(posedge clk);
        #1;
        check("flsq e_valid", 32'(e_valid), 32'd0);
        @(negedge clk);
        drive(1, ins(1, 1, 2, 3), 16'h0064, 0, 0);
        @(posedge clk);
        #1;
        checkE("flsq next", 1, 16'h1111, 16'h2222, 16'h0064);

        // Reset mid-stall with a squash pending.
        @(negedge clk);
        drive(1, ins(15, 0, 0, 2), 16'h0080, 0, 0);
        @(negedge clk);
        drive(1, ins(1, 1, 2, 3), 16'h0082, 1, 0);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkE("async reset", 0, 16'h0, 16'h0, 16'h0);
        check("async reset e_opcode", 32'(e_opcode), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive(1, ins(1, 1, 2, 3), 16'h0090, 0, 0);
        @(posedge clk);
        #1;
        checkE("post reset", 1, 16'h0, 16'h0, 16'h0090);

        @(negedge clk);
        drive(0, 16'h0, 16'h0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/decode_pipe.md
# decode_pipe

Parametrised decode stage for the 16-bit UART CPU. It splits the instruction into its fields and reads two operands from an internal register file with write-back bypass. It resolves branches in decode, detects load-use hazards, and holds the result in a registered decode-to-execute (D/E) pipeline stage with stall and flush control. It sits between the fetch stage (instruction and PC in) and the execute stage (D/E register out); write-back returns from the W stage.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- REG_ADDR_W, 4, register address width; register count is 2**REG_ADDR_W
- OPC_W, 4, opcode width
- INST_W, 16, instruction width; must equal OPC_W + 3*REG_ADDR_W
- PC_W, 16, program counter width
- LOAD_OPC, 4'h8, opcode of the load instruction
- IMM_OPC, 4'h9, opcode using an immediate as the second operand
- BR_OPC, 4'hF, opcode of the branch instruction

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  inst_d/pc_d valid from fetch
- in_ready  out  1  decode accepts this cycle
- inst_d  in  INST_W  instruction: [INST_W-1 -: OPC_W] opcode, then src1, src2, dest (each REG_ADDR_W bits, dest in the LSBs)
- pc_d  in  PC_W  PC of inst_d
- stall_i  in  1  downstream hold; D/E register keeps its contents
- flush_i  in  1  kill D/E contents and any pending squash
- wb_en  in  1  register-file write enable
- wb_addr  in  REG_ADDR_W  write address
- wb_data  in  DATA_W  write data
- e_valid  out  1  D/E slot holds a live instruction
- e_opcode  out  OPC_W  registered opcode
- e_src1, e_src2, e_dest  out  REG_ADDR_W  registered address fields
- e_data1, e_data2  out  DATA_W  registered operands
- e_pc  out  PC_W  registered PC
- br_take  out  1  combinational: a branch is being accepted this cycle
- br_target  out  PC_W  pc_d + sign-extended dest field
- hazard_stall  out  1  combinational: load-use hold this cycle

## Operation
- **Register file:**
  - 2**REG_ADDR_W x DATA_W; all entries reset to 0.
  - R0 always reads 0; writes to R0 are ignored.
  - Writes occur on the clock edge when wb_en is high.
  - Reads are combinational with a bypass: if wb_en is high, wb_addr equals the read address and the address is not 0, the read returns wb_data.
- **Operands:**
  - data1 = RF[src1].
  - data2 = RF[src2], except when the opcode is IMM_OPC: data2 = sign-extended src2 field.
- **Hazard:**
  - hazard_stall = in_valid & e_valid & (e_opcode==LOAD_OPC) & (e_dest!=0) & (e_dest==src1 | e_dest==src2) & (opcode!=BR_OPC).
  - With IMM_OPC, only src1 is compared.
- **Handshake:**
  - in_ready = !stall_i & !hazard_stall.
  - An instruction is accepted when in_valid & in_ready.
- **Squash:**
  - A 1-bit squash flag is set when a branch is accepted.
  - The next accepted instruction is loaded into D/E with e_valid=0 (the branch shadow is killed); the flag then clears.
- **Branch:**
  - br_take = in_valid & in_ready & opcode==BR_OPC & !squash & !flush_i.
  - A branch still enters D/E with e_valid=1 so execute can track it.
- **D/E update priority, per edge:**
  1. flush_i: e_valid←0; squash←0.
  2. stall_i: hold everything.
  3. hazard_stall: bubble inserted, e_valid←0; decode input is not consumed.
  4. Accepted instruction: load all fields; e_valid ← !squash.
  5. Otherwise: e_valid←0.
- **Arithmetic:** br_target wraps modulo 2**PC_W.

## Timing
- Reset: every output register, the squash flag and the register file go to 0 immediately, independent of clk. Combinational outputs follow from these values.
- Decode latency is one cycle: the instruction accepted at edge N appears on the e_* outputs after edge N.
- Write-back to D/E visibility:
  - Same cycle via the bypass.
  - A write at edge N is visible from the array after edge N.
- A load-use hazard costs exactly one bubble. The dependent instruction is accepted on the following cycle, once the load has left D/E.
- flush_i together with stall_i: the flush wins.
- flush_i together with a branch: br_take is suppressed.
- Reset asserted mid-stall or with squash pending: all state clears; the first instruction accepted after reset is live.

## Structure
- Shared package `cpu_pkg`: opcode constants (LOAD_OPC, IMM_OPC, BR_OPC), default widths, and field-slice helper functions.
- One sub-module: `regfile_bypass`, holding the array, the R0 rule and the bypass.
- Hazard, branch and D/E logic stay in `decode_pipe`.

## Test plan
- **Reset/readback:** assert reset mid-run, then issue ADD R3,R1,R2 → e_data1=e_data2=0 and e_valid=1 one cycle later.
- **Bypass:** wb_en=1, wb_addr=5, wb_data=16'hBEEF in the same cycle as decoding src1=5 → e_data1=16'hBEEF. Also write R0=16'h1234, then read R0 → 0.
- **Load-use:** LOAD dest=R4, followed by ADD src1=R4 → hazard_stall=1 for one cycle, one bubble (e_valid=0), then ADD enters D/E.
- **Branch:** BR at pc_d=16'h0010 with dest=4'hE → br_take=1 and br_target=16'h000E. The next accepted instruction gives e_valid=0; the one after is live.
- **Stall/flush:**
  - stall_i held 3 cycles → e_* unchanged and in_ready=0.
  - flush_i together with stall_i → e_valid=0 and a pending squash is cleared.
- **Immediate:** IMM_OPC with src2 field = 4'hF → e_data2=16'hFFFF, and no hazard is raised against a LOAD with dest=R15.
